ahb_lite_dma_master: RTL and testbench
======================================

// Module: ahb_lite_dma_master
// PURPOSE
//  AHB-Lite initiator (bus master) copy engine: moves LEN 32-bit words from SRC to DST with single
//  transfers. Counterpart of the existing AHB-Lite responders (DMEM, UART, TIMER, DUMP). It reaches
//  them through the same decoder/mux as the core data port, behind a 2-master arbiter.
//  Control comes from a simple cfg_* strobe interface. Completion and error are reported via irq.
// PARAMETERS
//  LEN_WIDTH   16   width of word-count register; max transfer = 2^LEN_WIDTH-1 words
//  ADDR_INC    4    byte increment per word (HSIZE=word); must be 4
// PORTS
//  clock       in   1   system clock
//  reset       in   1   synchronous, active-high reset
//  cfg_start   in   1   1-cycle pulse: latch cfg_src/cfg_dst/cfg_len, begin copy
//  cfg_src     in   32  source byte address (word aligned, [1:0] ignored)
//  cfg_dst     in   32  destination byte address (word aligned, [1:0] ignored)
//  cfg_len     in   LEN_WIDTH  number of words
//  cfg_abort   in   1   level: stop at next word boundary
//  cfg_fill    in   1   fill mode select (only with AHB_DMA_FILL_EN)
//  cfg_pattern in   32  fill word (only with AHB_DMA_FILL_EN)
//  busy        out  1   engine active
//  done        out  1   1-cycle pulse at end (normal, abort, or error)
//  err         out  1   sticky: HRESP error seen; cleared by the next accepted cfg_start
//  irq         out  1   level; set with done, cleared by cfg_start
//  remaining   out  LEN_WIDTH  words left
//  HADDR out 32; HTRANS out 2; HWRITE out 1; HSIZE out 3; HBURST out 3; HPROT out 4;
//  HMASTLOCK out 1; HWDATA out 32; HRDATA in 32; HREADY in 1; HRESP in 1
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE; HTRANS=2'b00; HADDR=0; HWRITE=0; HWDATA=0; busy=0;
//    done=0; err=0; irq=0; remaining=0.
//  - Constant outputs: HSIZE=3'b010, HBURST=3'b000, HPROT=4'b0011, HMASTLOCK=0.
//  - FSM states: IDLE, RD_A, RD_D, WR_A, WR_D, FIN.
//    IDLE: on cfg_start latch src/dst/len and clear err/irq. len==0 -> FIN, else RD_A.
//          cfg_start is ignored when busy=1.
//    RD_A: HADDR=src, HTRANS=NONSEQ, HWRITE=0. If HREADY -> RD_D; otherwise hold all address signals.
//    RD_D: HTRANS=IDLE. If HREADY&!HRESP: buf<=HRDATA -> WR_A. If HRESP -> err<=1, FIN.
//    WR_A: HADDR=dst, HTRANS=NONSEQ, HWRITE=1. If HREADY -> WR_D.
//    WR_D: HTRANS=IDLE, HWDATA=buf, held stable until HREADY.
//          If HREADY&!HRESP: src+=4, dst+=4, remaining-=1.
//          Then -> FIN if remaining==1 or cfg_abort, else RD_A. If HRESP -> err<=1, FIN.
//    FIN: done=1 for 1 cycle, irq<=1 -> IDLE.
//  - busy=1 in every state except IDLE.
//  - Latency per word, zero-wait slaves: 4 cycles. Start-to-done for N words: 4N+2 cycles.
//  - Addresses wrap modulo 2^32 (0xFFFF_FFFC+4 -> 0x0000_0000); no error is raised on wrap.
//  - HRESP: the data phase always drives HTRANS=IDLE, so the 2-cycle AHB error response is honoured.
//    err is captured in the first HRESP cycle; the FSM leaves only when HREADY is high.
//  - cfg_abort: never cuts an address or data phase; it is sampled only in the WR_D completion cycle.
//  - Reset mid-transfer: the bus returns to IDLE in the next cycle and the transfer is dropped.
// CONFIGURATION
//  AHB_DMA_FILL_EN defined: cfg_fill=1 at cfg_start latches cfg_pattern into buf.
//    The FSM skips RD_A/RD_D (IDLE->WR_A, WR_D->WR_A): 2 cycles/word, 2N+2 total.
//  AHB_DMA_FILL_EN undefined: cfg_fill and cfg_pattern are ignored; always copy mode.
// TESTING
//  - Copy: src=0x1C01_0000, dst=0x1C01_0100, len=4, zero-wait memory -> 4 NONSEQ reads and 4 writes,
//    dst words equal src words, done at cycle 18, irq=1, err=0.
//  - Wait states: slave holds HREADY=0 for 3 cycles per phase, len=2 -> HADDR/HWDATA stable while
//    stalled, data correct, done at cycle 4*2*4+2=34.
//  - Error: HRESP on 2nd read, len=3 -> err=1, no 2nd write issued, remaining=2, done pulse, irq=1.
//  - len=0 and start-while-busy: done 2 cycles after start with no HTRANS!=IDLE.
//    A second cfg_start while busy leaves src/dst/len unchanged.
//  - Abort and wrap: src=0xFFFF_FFF8, len=4, cfg_abort raised after the 2nd write
//    -> reads at FFFF_FFF8 and FFFF_FFFC, remaining=2, done.
//    Without abort, the 3rd read is at 0x0000_0000.
//  - Fill (AHB_DMA_FILL_EN): cfg_fill=1, pattern=0xDEADBEEF, len=3 -> 3 writes only, done at cycle 8.

Source files
------------

// File: rtl/ahb_lite_dma_master.sv
// rtl/ahb_lite_dma_master.sv - AHB-Lite single-transfer word copy engine
// Optional fill mode (repeat one pattern word, no reads) is built when AHB_DMA_FILL_EN is defined.
module ahb_lite_dma_master #(
  parameter int LEN_WIDTH = 16,
  parameter int ADDR_INC  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic [31:0]          cfg_src,
  input  logic [31:0]          cfg_dst,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic                 cfg_abort,
  input  logic                 cfg_fill,
  input  logic [31:0]          cfg_pattern,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 irq,
  output logic [LEN_WIDTH-1:0] remaining,
  output logic [31:0]          HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic [3:0]           HPROT,
  output logic                 HMASTLOCK,
  output logic [31:0]          HWDATA,
  input  logic [31:0]          HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP
);

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_D, S_WR_A, S_WR_D, S_FIN} state_t;

  state_t      state, state_nx;
  logic [31:0] src, dst, data_buf;
  logic        start_fill, skip_read;
  logic        accept;

  assign accept = (state == S_IDLE) && cfg_start;

`ifdef AHB_DMA_FILL_EN
  logic fill_mode;
  always_ff @(posedge clock) begin
    if (reset) fill_mode <= 1'b0;
    else if (accept) fill_mode <= cfg_fill;
  end
  assign start_fill = cfg_fill;
  assign skip_read  = fill_mode;
`else
  logic unused_fill;
  assign unused_fill = cfg_fill;
  assign start_fill  = 1'b0;
  assign skip_read   = 1'b0;
`endif

  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign busy      = (state != S_IDLE);

  // Data phases always present HTRANS=IDLE, so the two-cycle error response never overlaps a new address.
  always_comb begin
    state_nx = state;
    HADDR    = 32'h0;
    HTRANS   = 2'b00;
    HWRITE   = 1'b0;
    HWDATA   = 32'h0;
    case (state)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_len == '0) state_nx = S_FIN;
          else if (start_fill) state_nx = S_WR_A;
          else state_nx = S_RD_A;
        end
      end
      S_RD_A: begin
        HADDR  = src;
        HTRANS = 2'b10;
        if (HREADY) state_nx = S_RD_D;
      end
      S_RD_D: begin
        if (HREADY) state_nx = HRESP ? S_FIN : S_WR_A;
      end
      S_WR_A: begin
        HADDR  = dst;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        if (HREADY) state_nx = S_WR_D;
      end
      S_WR_D: begin
        HWDATA = data_buf;
        if (HREADY) begin
          if (HRESP || remaining == LEN_WIDTH'(1) || cfg_abort) state_nx = S_FIN;
          else if (skip_read) state_nx = S_WR_A;
          else state_nx = S_RD_A;
        end
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      src       <= 32'h0;
      dst       <= 32'h0;
      data_buf  <= 32'h0;
      remaining <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == S_FIN);
      if (accept) begin
        src       <= {cfg_src[31:2], 2'b00};
        dst       <= {cfg_dst[31:2], 2'b00};
        remaining <= cfg_len;
        err       <= 1'b0;
        irq       <= 1'b0;
        if (start_fill) data_buf <= cfg_pattern;
      end
      if (state == S_RD_D && HREADY && !HRESP) data_buf <= HRDATA;
      // err latches in the first HRESP cycle, while HREADY may still be low.
      if ((state == S_RD_D || state == S_WR_D) && HRESP) err <= 1'b1;
      if (state == S_WR_D && HREADY && !HRESP) begin
        src       <= src + 32'(ADDR_INC);
        dst       <= dst + 32'(ADDR_INC);
        remaining <= remaining - LEN_WIDTH'(1);
      end
      if (state == S_FIN) irq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_lite_dma_master.sv
// tb/tb_ahb_lite_dma_master.sv - directed self-checking bench for ahb_lite_dma_master
// Includes a behavioural AHB-Lite responder with programmable wait states and error injection.
module tb_ahb_lite_dma_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_src = 32'h0;
  logic [31:0] cfg_dst = 32'h0;
  logic [15:0] cfg_len = 16'h0;
  logic        cfg_abort = 1'b0;
  logic        cfg_fill = 1'b0;
  logic [31:0] cfg_pattern = 32'h0;
  logic        busy, done, err, irq;
  logic [15:0] remaining;
  logic [31:0] haddr, hwdata;
  logic [31:0] hrdata = 32'h0;
  logic [1:0]  htrans;
  logic        hwrite, hmastlock;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  ahb_lite_dma_master #(.LEN_WIDTH(16), .ADDR_INC(4)) dut (
    .clock(clock), .reset(reset), .cfg_start(cfg_start), .cfg_src(cfg_src), .cfg_dst(cfg_dst),
    .cfg_len(cfg_len), .cfg_abort(cfg_abort), .cfg_fill(cfg_fill), .cfg_pattern(cfg_pattern),
    .busy(busy), .done(done), .err(err), .irq(irq), .remaining(remaining),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HRDATA(hrdata),
    .HREADY(hready), .HRESP(hresp)
  );

  always #5 clock = ~clock;

  // Responder state; configuration (ws, err_target, src_mem) is written only by the main sequence.
  logic [31:0] src_mem [0:255];
  int          ws = 0;
  int          err_target = -1;
  int          rd_cnt = 0;
  int          viol = 0;
  int          nonidle = 0;
  int          cnt = 0;
  bit          dp_active = 1'b0;
  bit          dp_write = 1'b0;
  bit          err_second = 1'b0;
  bit          last_stall = 1'b0;
  logic [31:0] dp_addr = 32'h0;
  logic [31:0] last_haddr = 32'h0;
  logic [31:0] last_hwdata = 32'h0;
  logic [31:0] log_addr[$];
  bit          log_wr[$];
  logic [31:0] log_data[$];

  always @(negedge clock) begin
    if (reset) begin
      hready = 1'b1; hresp = 1'b0; dp_active = 1'b0; cnt = 0;
      err_second = 1'b0; last_stall = 1'b0;
    end else begin
      if (last_stall && htrans[1] && haddr !== last_haddr) viol++;
      if (last_stall && dp_active && dp_write && hwdata !== last_hwdata) viol++;
      if (htrans != 2'b00) nonidle++;
      hresp = 1'b0;
      if (err_second) begin
        hready = 1'b1; hresp = 1'b1; err_second = 1'b0; dp_active = 1'b0;
      end else if (dp_active || htrans[1]) begin
        if (cnt < ws) begin
          hready = 1'b0; cnt++;
        end else begin
          cnt = 0;
          if (dp_active && !dp_write && rd_cnt == err_target) begin
            hready = 1'b0; hresp = 1'b1; err_second = 1'b1; rd_cnt++;
          end else begin
            hready = 1'b1;
            if (dp_active) begin
              if (dp_write) begin
                log_addr.push_back(dp_addr); log_wr.push_back(1'b1); log_data.push_back(hwdata);
              end else begin
                hrdata = src_mem[dp_addr[9:2]];
                rd_cnt++;
                log_addr.push_back(dp_addr); log_wr.push_back(1'b0); log_data.push_back(hrdata);
              end
            end
            dp_active = htrans[1]; dp_addr = haddr; dp_write = hwrite;
          end
        end
      end else begin
        hready = 1'b1;
      end
      last_stall = !hready; last_haddr = haddr; last_hwdata = hwdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle 0 carries cfg_start; cyc returns the cycle number in which done is seen high.
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                     input int abort_at, input int poke_at,
                     output int cyc, output logic irq1, output logic done_after);
    @(negedge clock);
    cfg_src = s; cfg_dst = d; cfg_len = n; cfg_start = 1'b1;
    @(posedge clock); #1;
    cfg_start = 1'b0; cyc = 1; irq1 = irq;
    while (done !== 1'b1 && cyc < 400) begin
      if (cyc == abort_at) cfg_abort = 1'b1;
      if (cyc == poke_at) begin
        cfg_start = 1'b1; cfg_src = 32'h1C01_0080; cfg_dst = 32'h1C01_00C0; cfg_len = 16'd9;
      end else begin
        cfg_start = 1'b0;
      end
      @(posedge clock); #1;
      cyc++;
    end
    cfg_start = 1'b0; cfg_abort = 1'b0;
    @(posedge clock); #1;
    done_after = done;
  endtask

  initial begin
    int   cyc, lb, v0, ni0;
    logic irq1, dn;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_irq", irq, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_htrans", htrans, 0);
    chk("rst_haddr", haddr, 0);
    chk("rst_hwrite", hwrite, 0);
    chk("rst_hwdata", hwdata, 0);
    chk("const_hsize", hsize, 3'b010);
    chk("const_hburst", hburst, 3'b000);
    chk("const_hprot", hprot, 4'b0011);
    chk("const_hmastlock", hmastlock, 0);
    @(negedge clock); reset = 1'b0;

    // Zero-wait copy of 4 words
    for (int i = 0; i < 4; i++) src_mem[i] = 32'hA5A5_0000 + 32'(i);
    lb = log_addr.size();
    run(32'h1C01_0000, 32'h1C01_0100, 16'd4, -1, -1, cyc, irq1, dn);
    chk("copy_done_cycle", cyc, 18);
    chk("copy_irq_cleared", irq1, 0);
    chk("copy_log_size", log_addr.size() - lb, 8);
    for (int i = 0; i < 4; i++) begin
      chk("copy_rd_addr", log_addr[lb+2*i], 32'h1C01_0000 + 32'(4*i));
      chk("copy_rd_dir", log_wr[lb+2*i], 0);
      chk("copy_wr_addr", log_addr[lb+2*i+1], 32'h1C01_0100 + 32'(4*i));
      chk("copy_wr_dir", log_wr[lb+2*i+1], 1);
      chk("copy_wr_data", log_data[lb+2*i+1], 32'hA5A5_0000 + 32'(i));
    end
    chk("copy_irq", irq, 1);
    chk("copy_err", err, 0);
    chk("copy_remaining", remaining, 0);
    chk("copy_busy", busy, 0);
    chk("copy_done_pulse", dn, 0);

    // Three wait states on every phase
    ws = 3; v0 = viol;
    src_mem[0] = 32'hCAFE_0001; src_mem[1] = 32'hCAFE_0002;
    lb = log_addr.size();
    run(32'h1C01_0000, 32'h1C01_0200, 16'd2, -1, -1, cyc, irq1, dn);
    chk("wait_done_cycle", cyc, 34);
    chk("wait_stable", viol - v0, 0);
    chk("wait_log_size", log_addr.size() - lb, 4);
    chk("wait_wr0_data", log_data[lb+1], 32'hCAFE_0001);
    chk("wait_wr1_addr", log_addr[lb+3], 32'h1C01_0204);
    chk("wait_wr1_data", log_data[lb+3], 32'hCAFE_0002);
    ws = 0;

    // Error response on the second read
    err_target = rd_cnt + 1;
    lb = log_addr.size();
    run(32'h1C01_0000, 32'h1C01_0100, 16'd3, -1, -1, cyc, irq1, dn);
    chk("err_done_cycle", cyc, 9);
    chk("err_flag", err, 1);
    chk("err_irq", irq, 1);
    chk("err_remaining", remaining, 2);
    chk("err_log_size", log_addr.size() - lb, 2);
    chk("err_one_write", log_wr[lb+1], 1);
    err_target = -1;

    // Zero length: no bus activity, start clears err and irq
    lb = log_addr.size(); ni0 = nonidle;
    run(32'h1C01_0000, 32'h1C01_0100, 16'd0, -1, -1, cyc, irq1, dn);
    chk("len0_done_cycle", cyc, 2);
    chk("len0_irq_cleared", irq1, 0);
    chk("len0_err_cleared", err, 0);
    chk("len0_no_transfers", log_addr.size() - lb, 0);
    chk("len0_bus_idle", nonidle - ni0, 0);
    chk("len0_irq", irq, 1);

    // cfg_start while busy must be ignored
    src_mem[0] = 32'h0BAD_F00D; src_mem[1] = 32'h1234_5678;
    lb = log_addr.size();
    run(32'h1C01_0000, 32'h1C01_0300, 16'd2, -1, 3, cyc, irq1, dn);
    chk("busy_start_done_cycle", cyc, 10);
    chk("busy_start_log_size", log_addr.size() - lb, 4);
    chk("busy_start_rd1_addr", log_addr[lb+2], 32'h1C01_0004);
    chk("busy_start_wr1_addr", log_addr[lb+3], 32'h1C01_0304);
    chk("busy_start_wr1_data", log_data[lb+3], 32'h1234_5678);

    // Abort after the second write near the top of the address space
    src_mem[254] = 32'h1111_2222; src_mem[255] = 32'h3333_4444;
    src_mem[0] = 32'h5555_6666; src_mem[1] = 32'h7777_8888;
    lb = log_addr.size();
    run(32'hFFFF_FFF8, 32'h1C01_0100, 16'd4, 5, -1, cyc, irq1, dn);
    chk("abort_done_cycle", cyc, 10);
    chk("abort_remaining", remaining, 2);
    chk("abort_log_size", log_addr.size() - lb, 4);
    chk("abort_rd0_addr", log_addr[lb], 32'hFFFF_FFF8);
    chk("abort_rd1_addr", log_addr[lb+2], 32'hFFFF_FFFC);
    chk("abort_wr1_data", log_data[lb+3], 32'h3333_4444);

    // Same start without abort wraps to address zero
    lb = log_addr.size();
    run(32'hFFFF_FFF8, 32'h1C01_0100, 16'd4, -1, -1, cyc, irq1, dn);
    chk("wrap_done_cycle", cyc, 18);
    chk("wrap_rd2_addr", log_addr[lb+4], 32'h0000_0000);
    chk("wrap_rd3_addr", log_addr[lb+6], 32'h0000_0004);
    chk("wrap_wr2_data", log_data[lb+5], 32'h5555_6666);
    chk("wrap_err", err, 0);

`ifdef AHB_DMA_FILL_EN
    cfg_fill = 1'b1; cfg_pattern = 32'hDEAD_BEEF;
    lb = log_addr.size();
    run(32'h1C01_0000, 32'h1C01_0100, 16'd3, -1, -1, cyc, irq1, dn);
    chk("fill_done_cycle", cyc, 8);
    chk("fill_log_size", log_addr.size() - lb, 3);
    for (int i = 0; i < 3; i++) begin
      chk("fill_dir", log_wr[lb+i], 1);
      chk("fill_addr", log_addr[lb+i], 32'h1C01_0100 + 32'(4*i));
      chk("fill_data", log_data[lb+i], 32'hDEAD_BEEF);
    end
    cfg_fill = 1'b0;
`else
    cfg_fill = 1'b1; cfg_pattern = 32'hDEAD_BEEF;
    src_mem[0] = 32'h0F0F_0F0F;
    lb = log_addr.size();
    run(32'h1C01_0000, 32'h1C01_0100, 16'd1, -1, -1, cyc, irq1, dn);
    chk("nofill_done_cycle", cyc, 6);
    chk("nofill_log_size", log_addr.size() - lb, 2);
    chk("nofill_reads", log_wr[lb], 0);
    chk("nofill_data", log_data[lb+1], 32'h0F0F_0F0F);
    cfg_fill = 1'b0;
`endif

    // Reset in the middle of a transfer returns the bus to IDLE next cycle
    @(negedge clock);
    cfg_src = 32'h1C01_0000; cfg_dst = 32'h1C01_0100; cfg_len = 16'd4; cfg_start = 1'b1;
    @(posedge clock); #1;
    cfg_start = 1'b0;
    chk("midrst_htrans_before", htrans, 2'b10);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst_htrans", htrans, 2'b00);
    chk("midrst_busy", busy, 0);
    chk("midrst_remaining", remaining, 0);
    @(negedge clock); reset = 1'b0;
    repeat (2) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
